// File: rtl/sum_acc_pkg.sv
// -----------------------------------------------------------------------------
// sum_acc_pkg
//   Shared definitions for the block sum accumulator.
//
//   Contents:
//     DEF_BLOCK_LEN : default number of samples per accumulation block
//     DEF_ACC_W     : default accumulator / result width in bits
//     CNT_W         : width of the sample counter and of out_count
//     state_t       : accumulator FSM states
//                       ACCUM - collecting samples, in_ready high
//                       HOLD  - presenting a finished result, out_valid high
// -----------------------------------------------------------------------------
package sum_acc_pkg;

  localparam int DEF_BLOCK_LEN = 8;
  localparam int DEF_ACC_W     = 8;

  // Block length tops out at 255, so an 8-bit counter always suffices.
  localparam int CNT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage : sum_acc_pkg

// File: rtl/acc_sat_add.sv
// -----------------------------------------------------------------------------
// acc_sat_add
//   Combinational saturating adder: adds a 2-bit unsigned sample to an
//   ACC_W-bit unsigned accumulator and clamps the result at 2^ACC_W-1.
//
//   Parameters:
//     ACC_W  : accumulator width in bits (2..16)
//
//   Ports:
//     acc    in  ACC_W : current accumulator value
//     addend in  2     : unsigned sample, 0..3
//     sum    out ACC_W : acc + addend, clamped to all-ones on overflow
//     sat    out 1     : high when the true sum exceeded 2^ACC_W-1
// -----------------------------------------------------------------------------
module acc_sat_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [1:0]       addend,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // One extra bit catches the carry out of the full-width add.
  logic [ACC_W:0] wide;

  // NOTE: every output of a combinational block is assigned on every path;
  // a missing assignment would make the tool infer a latch.
  always_comb begin
    wide = {1'b0, acc} + {{(ACC_W - 1){1'b0}}, addend};
    sat  = wide[ACC_W];
    sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end

endmodule : acc_sat_add

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//   Collects 2-bit samples from the upstream adder stage into blocks of up to
//   BLOCK_LEN samples, summing them into a saturating ACC_W-bit accumulator.
//   A block closes when it reaches BLOCK_LEN samples or when flush is seen
//   with at least one sample in it. The finished result is held on the output
//   handshake until the downstream stage takes it; accumulation then resumes
//   on the following cycle (one bubble per block).
//
//   Parameters:
//     BLOCK_LEN : samples per block (1..255)
//     ACC_W     : accumulator / result width (2..16)
//
//   Ports:
//     clk       in  1     : clock, all state on the rising edge
//     rst       in  1     : asynchronous active-high reset
//     in_valid  in  1     : in_data carries a valid sample
//     in_data   in  2     : unsigned sample, 0..3
//     in_ready  out 1     : a sample is accepted this cycle (ACCUM)
//     flush     in  1     : close the current block early
//     out_valid out 1     : a result is presented (HOLD)
//     out_ready in  1     : downstream takes the result
//     out_sum   out ACC_W : saturated block sum
//     out_count out 8     : samples in the block, 1..BLOCK_LEN
//     out_ovf   out 1     : saturation occurred within the block
// -----------------------------------------------------------------------------
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

  state_t state;
  state_t state_next;

  // Running block state.
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  // Saturating adder outputs.
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;

  // Values the block state takes after this edge's transfer, if any.
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;

  logic take_in;
  logic take_out;
  logic close_blk;

  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc),
    .addend (in_data),
    .sum    (add_sum),
    .sat    (add_sat)
  );

  // ---------------------------------------------------------------------------
  // Handshakes and block-close decision
  // ---------------------------------------------------------------------------
  always_comb begin
    take_in  = in_valid & in_ready;
    take_out = out_valid & out_ready;

    acc_upd  = take_in ? add_sum : acc;
    ovf_upd  = ovf | (take_in & add_sat);
    cnt_upd  = cnt + {{(CNT_W - 1){1'b0}}, take_in};

    // A same-edge sample counts toward both the full-block and the flush
    // conditions, so a flush arriving with the last sample closes once and
    // includes that sample. Flush on an empty block does nothing.
    close_blk = (state == ACCUM) &&
                ((take_in && (cnt_upd == BLOCK_LEN_C)) ||
                 (flush && (cnt_upd != '0)));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (close_blk) state_next = HOLD;
      HOLD:  if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
  end

  // ---------------------------------------------------------------------------
  // Datapath: block accumulation and result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          acc <= acc_upd;
          cnt <= cnt_upd;
          ovf <= ovf_upd;
          // The result registers are loaded only when the block closes and
          // stay frozen for the whole HOLD period.
          if (close_blk) begin
            out_sum   <= acc_upd;
            out_count <= cnt_upd;
            out_ovf   <= ovf_upd;
          end
        end
        HOLD: begin
          // Clearing on the release edge leaves the next block empty when
          // in_ready returns on the following cycle.
          if (take_out) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
      endcase
    end
  end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//   Self-checking bench for sum_accumulator. The main instance uses default
//   parameters and is compared every cycle against a queue-based block model.
//   A second instance with ACC_W=4 exercises saturation.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  localparam int BLEN  = 8;
  localparam int AW    = 8;
  localparam int MAXV  = (1 << AW) - 1;
  localparam int S_AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  // Default-parameter instance.
  logic          in_valid = 1'b0;
  logic [1:0]    in_data  = '0;
  logic          in_ready;
  logic          flush    = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic [7:0]    out_count;
  logic          out_ovf;

  // Narrow-accumulator instance.
  logic            s_in_valid  = 1'b0;
  logic [1:0]      s_in_data   = '0;
  logic            s_in_ready;
  logic            s_flush     = 1'b0;
  logic            s_out_valid;
  logic            s_out_ready = 1'b0;
  logic [S_AW-1:0] s_out_sum;
  logic [7:0]      s_out_count;
  logic            s_out_ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model: the samples of the open block, plus the pending result.
  int m_blk[$];
  bit m_hold;
  int exp_sum;
  int exp_cnt;
  bit exp_ovf;
  int accepted;
  int delivered;

  always #5 clk = ~clk;

  sum_accumulator #(
    .BLOCK_LEN (BLEN),
    .ACC_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  sum_accumulator #(
    .BLOCK_LEN (8),
    .ACC_W     (S_AW)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_data   (s_in_data),
    .in_ready  (s_in_ready),
    .flush     (s_flush),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_sum   (s_out_sum),
    .out_count (s_out_count),
    .out_ovf   (s_out_ovf)
  );

  task automatic model_reset();
    m_blk.delete();
    m_hold  = 1'b0;
    exp_sum = 0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
  endtask

  // The block result follows directly from the collected samples: all
  // addends are non-negative, so saturation happened iff the true total
  // exceeds the maximum, and the saturated sum is the clamped total.
  task automatic close_block();
    int total;
    total = 0;
    foreach (m_blk[i]) total += m_blk[i];
    exp_cnt = m_blk.size();
    exp_ovf = (total > MAXV);
    exp_sum = exp_ovf ? MAXV : total;
    m_blk.delete();
    m_hold = 1'b1;
  endtask

  // One clock cycle on the main instance: compare outputs with the model
  // (called just after a falling edge), drive inputs, advance the model
  // over the coming rising edge, then return at the next falling edge.
  task automatic step(input bit v, input logic [1:0] d, input bit f, input bit r);
    checks++;
    if (in_ready !== !m_hold) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, !m_hold, $time);
    end
    checks++;
    if (out_valid !== m_hold) begin
      failures++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_hold, $time);
    end
    if (m_hold) begin
      checks++;
      if (out_sum !== AW'(exp_sum)) begin
        failures++;
        $display("FAIL out_sum: got %0d expected %0d at %0t", out_sum, exp_sum, $time);
      end
      checks++;
      if (out_count !== 8'(exp_cnt)) begin
        failures++;
        $display("FAIL out_count: got %0d expected %0d at %0t", out_count, exp_cnt, $time);
      end
      checks++;
      if (out_ovf !== exp_ovf) begin
        failures++;
        $display("FAIL out_ovf: got %b expected %b at %0t", out_ovf, exp_ovf, $time);
      end
    end

    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;

    if (!m_hold) begin
      if (v) begin
        m_blk.push_back(int'(d));
        accepted++;
      end
      if (m_blk.size() == BLEN || (f && m_blk.size() >= 1)) close_block();
    end else if (r) begin
      m_hold = 1'b0;
      delivered += exp_cnt;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  // Close any open block and hand off any pending result.
  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== '0 || out_count !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_result: got sum=%0d count=%0d ovf=%b expected 0/0/0",
               out_sum, out_count, out_ovf);
    end
    rst = 1'b0;
    // The very next edge must already accept a sample.
    step(1'b1, 2'd2, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 8'd1 || out_sum !== 8'd2) begin
      failures++;
      $display("FAIL reset_release: got valid=%b count=%0d sum=%0d expected 1/1/2",
               out_valid, out_count, out_sum);
    end
    drain();
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_handshake: got out_valid=%b in_ready=%b expected 0/1",
               out_valid, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd8 || out_count !== 8'd8 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL midreset_result: got valid=%b sum=%0d count=%0d ovf=%b expected 1/8/8/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    drain();
  endtask

  task automatic test_full_block();
    int low_cycles;
    low_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready === 1'b0) low_cycles++;
      if (i == 8) begin
        checks++;
        if (out_sum !== 8'd24 || out_count !== 8'd8 || out_ovf !== 1'b0) begin
          failures++;
          $display("FAIL full_block: got sum=%0d count=%0d ovf=%b expected 24/8/0",
                   out_sum, out_count, out_ovf);
        end
      end
      step(1'b1, 2'd3, 1'b0, 1'b1);
    end
    checks++;
    if (low_cycles != 1) begin
      failures++;
      $display("FAIL bubble: got %0d in_ready-low cycles expected 1", low_cycles);
    end
    drain();
  endtask

  task automatic test_flush();
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd6 || out_count !== 8'd3) begin
      failures++;
      $display("FAIL flush_result: got valid=%b sum=%0d count=%0d expected 1/6/3",
               out_valid, out_sum, out_count);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    // Flush on an empty block must not create a result.
    step(1'b0, 2'd3, 1'b1, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // Flush arriving while a result is held is ignored.
    step(1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 8'd1) begin
      failures++;
      $display("FAIL flush_in_hold: got valid=%b count=%0d expected 1/1", out_valid, out_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < BLEN; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    // One sample then flush: a count of 1 shows no stalled sample leaked in.
    step(1'b1, 2'd2, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 8'd1 || out_sum !== 8'd2) begin
      failures++;
      $display("FAIL backpressure_leak: got valid=%b count=%0d sum=%0d expected 1/1/2",
               out_valid, out_count, out_sum);
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 8; i++) begin
        s_in_valid = 1'b1;
        s_in_data  = (blk == 0) ? 2'd3 : 2'd1;
        @(posedge clk);
        @(negedge clk);
      end
      s_in_valid = 1'b0;
      checks++;
      if (blk == 0 && (s_out_valid !== 1'b1 || s_out_sum !== 4'd15 ||
                       s_out_ovf !== 1'b1 || s_out_count !== 8'd8)) begin
        failures++;
        $display("FAIL sat_block: got valid=%b sum=%0d ovf=%b count=%0d expected 1/15/1/8",
                 s_out_valid, s_out_sum, s_out_ovf, s_out_count);
      end
      if (blk == 1 && (s_out_valid !== 1'b1 || s_out_sum !== 4'd8 ||
                       s_out_ovf !== 1'b0 || s_out_count !== 8'd8)) begin
        failures++;
        $display("FAIL sat_next_block: got valid=%b sum=%0d ovf=%b count=%0d expected 1/8/0/8",
                 s_out_valid, s_out_sum, s_out_ovf, s_out_count);
      end
      s_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_out_ready = 1'b0;
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL sat_release: got out_valid=%b in_ready=%b expected 0/1",
                 s_out_valid, s_in_ready);
      end
    end
  endtask

  task automatic test_random();
    accepted  = 0;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
    end
    drain();
    checks++;
    if (delivered != accepted || accepted == 0) begin
      failures++;
      $display("FAIL random_count: got %0d delivered samples expected %0d accepted",
               delivered, accepted);
    end
  endtask

  initial begin
    model_reset();
    accepted  = 0;
    delivered = 0;
    @(negedge clk);
    test_reset();
    test_reset_mid_block();
    test_full_block();
    test_flush();
    test_backpressure();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sum_accumulator

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter BLOCK_LEN, default 8: samples per accumulation block, legal range 1..255.
REQ-002 Parameter ACC_W, default 8: accumulator and result width in bits, legal range 2..16.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: in_data holds a valid 2-bit sum from the upstream adder stage.
REQ-006 in_data  input  2: unsigned sample, 0..3.
REQ-007 in_ready  output  1: block accepts a sample this cycle.
REQ-008 flush  input  1: close the current block early, sampled each cycle.
REQ-009 out_valid  output  1: a result is presented.
REQ-010 out_ready  input  1: the downstream stage takes the result.
REQ-011 out_sum  output  ACC_W: block sum, saturated.
REQ-012 out_count  output  8: number of samples in the block, 1..BLOCK_LEN.
REQ-013 out_ovf  output  1: saturation occurred within the block.

Function
REQ-014 A sample transfer occurs when in_valid and in_ready are high on the same edge; a result transfer occurs when out_valid and out_ready are high on the same edge.
REQ-015 The FSM has two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 In ACCUM, each transfer adds zero-extended in_data to acc and increments cnt.
REQ-017 If acc+in_data exceeds 2^ACC_W-1, acc is set to 2^ACC_W-1 and the sticky ovf flag is set.
REQ-018 ACCUM moves to HOLD on the edge where a transfer makes cnt equal BLOCK_LEN.
REQ-019 ACCUM moves to HOLD on an edge with flush=1 when cnt (after any same-edge transfer) is >=1.
REQ-020 A transfer on the same edge as flush is included in the block.
REQ-021 flush with cnt=0 and no transfer is ignored, with no state change.
REQ-022 flush in HOLD is ignored.
REQ-023 out_sum, out_count and out_ovf are registered copies of acc, cnt and ovf, stable throughout HOLD.
REQ-024 out_valid rises one cycle after the closing transfer or flush edge.
REQ-025 out_valid does not drop until a result transfer occurs.
REQ-026 A HOLD result transfer returns the FSM to ACCUM and clears acc, cnt and ovf on that edge.
REQ-027 in_ready rises the cycle after a HOLD result transfer, giving one bubble per block.
REQ-028 Sustained throughput is BLOCK_LEN samples per BLOCK_LEN+1 cycles when out_ready is held at 1.
REQ-029 in_data is ignored when in_valid=0; out_ready is ignored in ACCUM.

Reset
REQ-030 rst=1 forces the FSM to ACCUM and clears acc, cnt, ovf, out_sum, out_count and out_ovf.
REQ-031 During and after reset, out_valid=0 and in_ready=1.
REQ-032 Reset mid-block or in HOLD discards the partial or pending result without emitting it.
REQ-033 Deassertion of rst takes effect on the next clock edge with no extra wait cycles.

Structure
REQ-034 Package sum_acc_pkg holds the state enum typedef (ACCUM, HOLD) and the constants DEF_BLOCK_LEN=8 and DEF_ACC_W=8.
REQ-035 Saturating addition is a combinational sub-module acc_sat_add, parameterised by ACC_W, with outputs sum and sat.
REQ-036 All other logic is flat within sum_accumulator.

Verification
REQ-037 Reset-mid-block: with defaults, feed three samples of value 3, assert rst, then feed eight samples of value 1 -> no result for the first three samples; one result with out_sum=8, out_count=8, out_ovf=0.
REQ-038 Full block: with defaults and out_ready=1, feed eight samples of value 3 -> out_sum=24, out_count=8, out_ovf=0; in_ready is low for exactly one cycle.
REQ-039 Saturation: with ACC_W=4 and BLOCK_LEN=8, feed eight samples of value 3 -> out_sum=15, out_ovf=1; the next block of 1s gives out_sum=8, out_ovf=0.
REQ-040 Flush: feed values 2, 1 and assert flush together with a third sample of value 3 -> out_sum=6, out_count=3; flush on an empty block produces no output.
REQ-041 Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_sum stay stable, in_ready=0, and in_valid samples are not consumed.
REQ-042 Random-stall run: drive random in_valid, out_ready and flush for 2000 cycles -> the scoreboard's sum of all out_count values equals the number of accepted samples.
